dvp_frame_source: RTL and testbench
===================================

Name: dvp_frame_source

Overview:
- Transmit end of the camera parallel (DVP) interface. Replays a 320x240 monochrome frame buffer as an 8-bit YCbCr 4:2:2 byte stream with pclk, vsync and href.
- Drives the stereo capture path from stored frames in simulation and on the board, so the capture block and downstream memory logic run without a physical sensor.
- Sits between a synchronous frame-buffer read port and the capture block's camera inputs.

Parameters:
- H_ACTIVE, 320, active pixels per line (2*H_ACTIVE bytes per line).
- V_ACTIVE, 240, active lines per frame.
- H_BLANK, 16, byte periods with href low after each active line.
- V_FRONT, 2, blank lines (vsync low) before the first active line.
- V_BACK, 2, blank lines (vsync low) after the last active line.
- CHROMA, 8'h80, constant Cb/Cr byte value.

Ports:
- clk_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run frames while high.
- pclk  out  1  pixel clock, clk_50/2.
- vsync  out  1  frame valid, high across all active lines.
- href  out  1  line valid.
- data  out  8  byte stream.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  19  frame-buffer pixel address.
- rd_data  in  8  Y value, valid the cycle after rd_en.
- busy  out  1  high from frame start until return to IDLE.
- frame_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, all counters 0.
- Byte timing:
  - pclk toggles every clk_50 cycle while not IDLE. In IDLE it is held at 0.
  - One byte period is 2 clk_50 cycles.
  - data, href and vsync change only on the edge where pclk goes 1->0. They are stable across the pclk rising edge, where the receiver samples.
- States: IDLE, VFP, LINE, HBL, VBP.
- IDLE -> VFP on enable=1. busy goes to 1 on the same edge.
- VFP: vsync=0, href=0, data=0. Lasts V_FRONT*(2*H_ACTIVE+H_BLANK) byte periods, then -> LINE.
- LINE:
  - vsync=1, href=1 for 2*H_ACTIVE byte periods.
  - Even byte = CHROMA. Odd byte = Y of pixel x. Chroma always comes first in each pixel pair.
  - rd_en pulses 1 cycle at the start of each chroma byte. rd_addr = y*H_ACTIVE + x.
  - rd_data is registered on the following cycle and presented as the Y byte.
  - rd_addr runs 0 .. H_ACTIVE*V_ACTIVE-1 linearly per frame.
- HBL: vsync=1, href=0, data=0 for H_BLANK byte periods.
  - Then -> LINE if lines sent < V_ACTIVE.
  - Else vsync drops to 0 and -> VBP.
- VBP: vsync=0, href=0. Lasts V_BACK*(2*H_ACTIVE+H_BLANK) byte periods.
  - At its final cycle: frame_done=1 for one clk_50 cycle and rd_addr returns to 0.
  - Then -> VFP if enable=1, else -> IDLE with busy=0.
- enable deasserted mid-frame: the current frame always completes.
- enable low for one cycle in IDLE: no effect.
- Counters: byte counter is 11 bits, line counter is 9 bits. Both wrap only via state transitions; no overflow possible at the defaults.

Optional Feature:
- DVP_PATTERN_EN defined:
  - Adds input pattern_mode (1 bit).
  - When pattern_mode=1, the Y byte is (x + y + frame_count)[7:0]. frame_count is an 8-bit counter incremented at each frame_done and wraps 255->0.
  - rd_en stays 0 for the whole frame. pattern_mode is sampled only at the IDLE/VBP -> VFP transition.
- DVP_PATTERN_EN undefined: no pattern_mode port; Y always comes from rd_data.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, V_FRONT=1, V_BACK=1 unless stated):
- Reset released, enable=0 for 20 cycles -> pclk, vsync, href, data, rd_en, busy all 0.
- enable=1, rd_data returns 8'h10+addr -> 11 blank byte periods with vsync=0, then vsync=1. Line 0 bytes are 80,10,80,11,80,12,80,13. rd_addr goes 0,1,2,3 with one rd_en per pixel.
- Same run -> href low for exactly 3 byte periods between lines. Line 1 Y bytes are 14..17. vsync falls after the second HBL. frame_done pulses once after 11 VBP byte periods.
- Default parameters, receiver model attached -> 240 lines of 320 Y bytes each, matching memory contents; 76800 rd_en pulses per frame.
- enable dropped during line 0 -> frame completes, then IDLE with busy=0 and pclk=0. Reset asserted mid-LINE -> all outputs 0 immediately, asynchronously.
- DVP_PATTERN_EN with pattern_mode=1, two frames -> frame 0 line 1 Y bytes are 1,2,3,4; frame 1 line 0 Y bytes are 1,2,3,4; rd_en never asserted.

Source files
------------

// File: rtl/dvp_frame_source.sv
// dvp_frame_source: replays a frame buffer as a DVP YCbCr 4:2:2 byte stream, pclk = clk_50/2.
// Optional DVP_PATTERN_EN adds pattern_mode, which replaces rd_data with an x+y+frame ramp.
module dvp_frame_source #(
    parameter int         H_ACTIVE = 320,
    parameter int         V_ACTIVE = 240,
    parameter int         H_BLANK  = 16,
    parameter int         V_FRONT  = 2,
    parameter int         V_BACK   = 2,
    parameter logic [7:0] CHROMA   = 8'h80
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        enable,
`ifdef DVP_PATTERN_EN
    input  logic        pattern_mode,
`endif
    input  logic [7:0]  rd_data,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        rd_en,
    output logic [18:0] rd_addr,
    output logic        busy,
    output logic        frame_done
);
    localparam int         LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam logic [10:0] VFP_LAST  = 11'(V_FRONT * LINE_BYTES - 1);
    localparam logic [10:0] VBP_LAST  = 11'(V_BACK * LINE_BYTES - 1);
    localparam logic [10:0] ACT_LAST  = 11'(2 * H_ACTIVE - 1);
    localparam logic [10:0] HBL_LAST  = 11'(H_BLANK - 1);
    localparam logic [8:0]  LINES     = 9'(V_ACTIVE);

    typedef enum logic [2:0] {IDLE, VFP, LINE, HBL, VBP} state_t;

    state_t      state_q;
    logic [10:0] byte_q;
    logic [8:0]  line_q;
    logic        pclk_q, vsync_q, href_q, rd_en_q, busy_q, frame_done_q;
    logic [7:0]  data_q;
    logic [18:0] rd_addr_q;
    logic        pat;
    logic [7:0]  y_d;
    logic        fd_set;

    // frame_done must cover the last clk_50 cycle of VBP, so it is raised one edge early
    assign fd_set = state_q == VBP && !pclk_q && byte_q == VBP_LAST;

`ifdef DVP_PATTERN_EN
    logic       pat_q;
    logic [7:0] frame_q;
    logic       start;
    assign start = enable && (state_q == IDLE || (state_q == VBP && pclk_q && byte_q == VBP_LAST));
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            pat_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            if (start) pat_q <= pattern_mode;
            if (fd_set) frame_q <= frame_q + 8'd1;
        end
    end
    assign pat = pat_q;
    assign y_d = pat_q ? 8'(byte_q[10:1]) + line_q[7:0] + frame_q : rd_data;
`else
    assign pat = 1'b0;
    assign y_d = rd_data;
`endif

    // All byte-level updates happen while pclk_q is 1, i.e. on the pclk falling edge
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            line_q       <= '0;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (state_q == IDLE) begin
                pclk_q <= 1'b0;
                if (enable) begin
                    state_q <= VFP;
                    busy_q  <= 1'b1;
                    byte_q  <= '0;
                end
            end else begin
                pclk_q <= ~pclk_q;
                if (fd_set) begin
                    frame_done_q <= 1'b1;
                    rd_addr_q    <= '0;
                end
                if (pclk_q) begin
                    byte_q <= byte_q + 11'd1;
                    case (state_q)
                        VFP: if (byte_q == VFP_LAST) begin
                            state_q <= LINE;
                            byte_q  <= '0;
                            line_q  <= '0;
                            vsync_q <= 1'b1;
                            href_q  <= 1'b1;
                            data_q  <= CHROMA;
                            rd_en_q <= !pat;
                        end
                        LINE: if (byte_q == ACT_LAST) begin
                            state_q <= HBL;
                            byte_q  <= '0;
                            href_q  <= 1'b0;
                            data_q  <= '0;
                            line_q  <= line_q + 9'd1;
                        end else if (!byte_q[0]) begin
                            data_q    <= y_d;
                            rd_addr_q <= rd_addr_q + 19'd1;
                        end else begin
                            data_q  <= CHROMA;
                            rd_en_q <= !pat;
                        end
                        HBL: if (byte_q == HBL_LAST) begin
                            byte_q <= '0;
                            if (line_q < LINES) begin
                                state_q <= LINE;
                                href_q  <= 1'b1;
                                data_q  <= CHROMA;
                                rd_en_q <= !pat;
                            end else begin
                                state_q <= VBP;
                                vsync_q <= 1'b0;
                            end
                        end
                        VBP: if (byte_q == VBP_LAST) begin
                            byte_q <= '0;
                            if (enable) begin
                                state_q <= VFP;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_dvp_frame_source.sv
// tb_dvp_frame_source: directed bench on a 4x2 frame with a receiver sampling while pclk is high.
module tb_dvp_frame_source;
    logic        clk_50 = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        pclk, vsync, href, rd_en, busy, frame_done;
    logic [7:0]  data;
    logic [18:0] rd_addr;
`ifdef DVP_PATTERN_EN
    logic        pattern_mode = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [9:0]  bq[$];
    logic [9:0]  exp_q[$];
    logic [18:0] aq[$];
    int          fd_cnt = 0;
    int          fd_at = 0;

    dvp_frame_source #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .V_FRONT(1), .V_BACK(1), .CHROMA(8'h80)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .enable(enable),
`ifdef DVP_PATTERN_EN
        .pattern_mode(pattern_mode),
`endif
        .rd_data(rd_data),
        .pclk(pclk),
        .vsync(vsync),
        .href(href),
        .data(data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk_50 = ~clk_50;

    // synchronous frame buffer: word at addr holds 8'h10 + addr
    always @(posedge clk_50) if (rd_en) rd_data <= 8'h10 + rd_addr[7:0];

    // receiver: one byte per pclk high phase, plus read-strobe and frame_done logs
    always @(negedge clk_50) begin
        if (pclk) bq.push_back({vsync, href, data});
        if (rd_en) aq.push_back(rd_addr);
        if (frame_done) begin
            fd_cnt++;
            fd_at = bq.size();
        end
    end

    function automatic void build_frame(input bit pat, input logic [7:0] fc);
        repeat (11) exp_q.push_back(10'h000);
        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < 4; x++) begin
                exp_q.push_back({2'b11, 8'h80});
                exp_q.push_back({2'b11, pat ? 8'(x + l) + fc : 8'h10 + 8'(l * 4 + x)});
            end
            repeat (3) exp_q.push_back(10'h000 | {2'b10, 8'h00});
        end
        repeat (11) exp_q.push_back(10'h000);
    endfunction

    task automatic clear_logs();
        bq = {};
        aq = {};
        exp_q = {};
        fd_cnt = 0;
        fd_at = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_50); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;
        checks++;
        if ({pclk, vsync, href, data, rd_en, busy, frame_done, rd_addr} !== '0) begin
            failures++;
            $display("FAIL reset_held outputs=%h required 0", {pclk, vsync, href, data, rd_en, busy, frame_done, rd_addr});
        end
        reset = 1'b1;
        repeat (20) @(posedge clk_50);
        #1;
        checks++; if (pclk !== 1'b0) begin failures++; $display("FAIL idle_pclk got=%b want=0", pclk); end
        checks++; if (vsync !== 1'b0) begin failures++; $display("FAIL idle_vsync got=%b want=0", vsync); end
        checks++; if (href !== 1'b0) begin failures++; $display("FAIL idle_href got=%b want=0", href); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL idle_data got=%h want=00", data); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL idle_rd_en got=%b want=0", rd_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
        checks++; if (bq.size() != 0) begin failures++; $display("FAIL idle_bytes got=%0d want=0", bq.size()); end
    endtask

    task automatic test_frame();
        bit ok;
        clear_logs();
        build_frame(1'b0, 8'h00);
        enable = 1'b1;
        @(posedge clk_50); #1;
        enable = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy_start got=%b want=1", busy); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL frame_timeout busy=%b want=0", busy); end
        checks++; if (bq.size() != exp_q.size()) begin failures++; $display("FAIL frame_len got=%0d want=%0d", bq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL frame_byte[%0d] vs/hr/data got=%h want=%h", i, bq[i], exp_q[i]);
            end
        end
        checks++; if (aq.size() != 8) begin failures++; $display("FAIL frame_rd_count got=%0d want=8", aq.size()); end
        for (int i = 0; i < aq.size() && i < 8; i++) begin
            checks++;
            if (aq[i] !== 19'(i)) begin failures++; $display("FAIL frame_rd_addr[%0d] got=%0d want=%0d", i, aq[i], i); end
        end
        checks++; if (fd_cnt != 1) begin failures++; $display("FAIL frame_done_count got=%0d want=1", fd_cnt); end
        checks++; if (fd_at != 44) begin failures++; $display("FAIL frame_done_pos got=%0d want=44", fd_at); end
        checks++; if (rd_addr !== 19'd0) begin failures++; $display("FAIL frame_addr_rewind got=%0d want=0", rd_addr); end
        checks++; if (pclk !== 1'b0) begin failures++; $display("FAIL frame_idle_pclk got=%b want=0", pclk); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        clear_logs();
        enable = 1'b1;
        repeat (30) @(posedge clk_50);
        #1;
        checks++; if (href !== 1'b1) begin failures++; $display("FAIL drop_in_line href=%b want=1", href); end
        enable = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_timeout busy=%b want=0", busy); end
        checks++; if (bq.size() != 44) begin failures++; $display("FAIL drop_frame_len got=%0d want=44", bq.size()); end
        checks++; if (fd_cnt != 1) begin failures++; $display("FAIL drop_done_count got=%0d want=1", fd_cnt); end
        repeat (10) @(posedge clk_50);
        #1;
        checks++; if ({busy, pclk} !== 2'b00) begin failures++; $display("FAIL drop_stays_idle busy,pclk=%b want=00", {busy, pclk}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        clear_logs();
        build_frame(1'b0, 8'h00);
        build_frame(1'b0, 8'h00);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk_50); #1;
            seen = fd_cnt != 0;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_first_done_timeout count=%0d want=1", fd_cnt); end
        enable = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy=%b want=1", busy); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout busy=%b want=0", busy); end
        checks++; if (bq.size() != 88) begin failures++; $display("FAIL b2b_len got=%0d want=88", bq.size()); end
        for (int i = 0; i < exp_q.size() && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%h want=%h", i, bq[i], exp_q[i]); end
        end
        checks++; if (aq.size() != 16) begin failures++; $display("FAIL b2b_rd_count got=%0d want=16", aq.size()); end
        for (int i = 0; i < aq.size() && i < 16; i++) begin
            checks++;
            if (aq[i] !== 19'(i % 8)) begin failures++; $display("FAIL b2b_rd_addr[%0d] got=%0d want=%0d", i, aq[i], i % 8); end
        end
        checks++; if (fd_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", fd_cnt); end
    endtask

    task automatic test_async_reset();
        bit seen;
        clear_logs();
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk_50); #1;
            seen = href === 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL areset_reach_line href=%b want=1", href); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pclk, vsync, href, data, rd_en, busy, frame_done, rd_addr} !== '0) begin
            failures++;
            $display("FAIL areset_outputs got=%h want=0", {pclk, vsync, href, data, rd_en, busy, frame_done, rd_addr});
        end
        enable = 1'b0;
        @(posedge clk_50); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk_50);
        #1;
        checks++; if ({busy, pclk, vsync} !== 3'b000) begin failures++; $display("FAIL areset_idle got=%b want=000", {busy, pclk, vsync}); end
    endtask

`ifdef DVP_PATTERN_EN
    task automatic test_pattern();
        bit ok;
        bit seen;
        clear_logs();
        build_frame(1'b1, 8'h00);
        build_frame(1'b1, 8'h01);
        pattern_mode = 1'b1;
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk_50); #1;
            seen = fd_cnt != 0;
        end
        checks++; if (!seen) begin failures++; $display("FAIL pat_first_done_timeout count=%0d", fd_cnt); end
        enable = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL pat_timeout busy=%b want=0", busy); end
        checks++; if (bq.size() != 88) begin failures++; $display("FAIL pat_len got=%0d want=88", bq.size()); end
        for (int i = 0; i < exp_q.size() && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== exp_q[i]) begin failures++; $display("FAIL pat_byte[%0d] got=%h want=%h", i, bq[i], exp_q[i]); end
        end
        checks++; if (aq.size() != 0) begin failures++; $display("FAIL pat_rd_en count=%0d want=0", aq.size()); end
        pattern_mode = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
`ifdef DVP_PATTERN_EN
        test_pattern();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
